// File: rtl/dot_mac_pkg.sv
// Shared scalar types and single-precision arithmetic helpers for the dot-product datapath.
`ifndef SINGLE
`define SINGLE logic [31:0]
`endif

package dot_mac_pkg;

   // One lane operand: IEEE-754 single value plus a lane enable.
   typedef struct packed {
      logic [31:0] value;
      logic        valid;
   } Scalar;

   // Element type for lane vectors; the port declaration supplies [LANES].
   typedef Scalar ScalarVec_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   // Single-precision multiply, round-to-nearest-even, denormals flushed to zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic               sign;
      logic [7:0]         ea;
      logic [7:0]         eb;
      logic [47:0]        prod;
      logic [24:0]        mant;
      logic [23:0]        rest;
      logic               rnd;
      logic signed [10:0] exp;
      logic [31:0]        res;
      sign = a[31] ^ b[31];
      ea   = a[30:23];
      eb   = b[30:23];
      prod = '0;
      mant = '0;
      rest = '0;
      rnd  = 1'b0;
      exp  = '0;
      if ((ea == 8'hFF && a[22:0] != '0) || (eb == 8'hFF && b[22:0] != '0)) begin
         res = FP_QNAN;
      end else if (ea == 8'hFF || eb == 8'hFF) begin
         // Inf times zero is invalid; otherwise the infinity propagates.
         res = (ea == 8'h00 || eb == 8'h00) ? FP_QNAN : {sign, 8'hFF, 23'h0};
      end else if (ea == 8'h00 || eb == 8'h00) begin
         res = {sign, 31'h0};
      end else begin
         prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
         exp  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
         if (prod[47]) begin
            mant = {1'b0, prod[47:24]};
            rest = prod[23:0];
            exp  = exp + 11'sd1;
         end else begin
            mant = {1'b0, prod[46:23]};
            rest = {prod[22:0], 1'b0};
         end
         rnd  = rest[23] && ((rest[22:0] != '0) || mant[0]);
         mant = mant + {24'h0, rnd};
         if (mant[24]) begin
            mant = mant >> 1;
            exp  = exp + 11'sd1;
         end
         if (exp >= 11'sd255) begin
            res = {sign, 8'hFF, 23'h0};
         end else if (exp <= 11'sd0) begin
            res = {sign, 31'h0};
         end else begin
            res = {sign, exp[7:0], mant[22:0]};
         end
      end
      return res;
   endfunction

   // Single-precision add, round-to-nearest-even, denormals flushed to zero.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        x;
      logic [31:0]        y;
      logic [31:0]        res;
      logic [7:0]         d;
      logic [26:0]        mx;
      logic [26:0]        my;
      logic [26:0]        mask;
      logic               sticky;
      logic [27:0]        s;
      logic signed [10:0] exp;
      logic [4:0]         lz;
      logic               found;
      logic [24:0]        mant;
      logic               rnd;
      x = a; y = b; res = FP_ZERO; d = '0; mx = '0; my = '0; mask = '0;
      sticky = 1'b0; s = '0; exp = '0; lz = '0; found = 1'b0; mant = '0; rnd = 1'b0;
      if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0)) begin
         res = FP_QNAN;
      end else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) begin
         res = (a[31] != b[31]) ? FP_QNAN : a;
      end else if (a[30:23] == 8'hFF) begin
         res = a;
      end else if (b[30:23] == 8'hFF) begin
         res = b;
      end else if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
         res = {a[31] & b[31], 31'h0};
      end else if (a[30:23] == 8'h00) begin
         res = b;
      end else if (b[30:23] == 8'h00) begin
         res = a;
      end else begin
         // x carries the larger magnitude, so the result sign is x's sign.
         if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
         end else begin
            x = b; y = a;
         end
         d  = x[30:23] - y[30:23];
         mx = {1'b1, x[22:0], 3'b000};
         my = {1'b1, y[22:0], 3'b000};
         if (d >= 8'd27) begin
            sticky = 1'b1;
            my     = '0;
         end else begin
            mask   = ~(27'h7FF_FFFF << d);
            sticky = |(my & mask);
            my     = my >> d;
         end
         my[0] = my[0] | sticky;
         exp   = $signed({3'b000, x[30:23]});
         if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
         end else begin
            s = {1'b0, mx} - {1'b0, my};
         end
         if (s == '0) begin
            res = FP_ZERO;
         end else begin
            if (s[27]) begin
               s   = {1'b0, s[27:2], s[1] | s[0]};
               exp = exp + 11'sd1;
            end else begin
               for (int i = 26; i >= 0; i--) begin
                  if (!found && s[i]) begin
                     lz    = 5'(26 - i);
                     found = 1'b1;
                  end
               end
               s   = s << lz;
               exp = exp - $signed({6'b000000, lz});
            end
            mant = {1'b0, s[26:3]};
            rnd  = s[2] && (s[1] || s[0] || mant[0]);
            mant = mant + {24'h0, rnd};
            if (mant[24]) begin
               mant = mant >> 1;
               exp  = exp + 11'sd1;
            end
            if (exp >= 11'sd255) begin
               res = {x[31], 8'hFF, 23'h0};
            end else if (exp <= 11'sd0) begin
               res = {x[31], 31'h0};
            end else begin
               res = {x[31], exp[7:0], mant[22:0]};
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dot_mac_fp_add_tree.sv
// Registered pairwise reduction tree: log2(LANES) levels, element 2i + element 2i+1 per level.
module fp_add_tree
   import dot_mac_pkg::*;
#(
   parameter int LANES = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        in_valid,
   input  logic        in_last,
   input  logic [31:0] vals [LANES],
   output logic [31:0] sum,
   output logic        valid,
   output logic        last
);

   localparam int LEVELS = $clog2(LANES);

   genvar gi, gj;

   generate
      if (LEVELS == 0) begin : g_pass
         assign sum   = vals[0];
         assign valid = in_valid;
         assign last  = in_last;
      end else begin : g_tree
         localparam int HALF = LANES / 2;

         logic [31:0]       node_reg  [LEVELS][HALF];
         logic [31:0]       node_next [LEVELS][HALF];
         logic [LEVELS-1:0] valid_reg;
         logic [LEVELS-1:0] last_reg;

         for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            for (gj = 0; gj < HALF; gj++) begin : g_node
               if (gj < (LANES >> (gi + 1))) begin : g_add
                  if (gi == 0) begin : g_first
                     assign node_next[gi][gj] = fp_add(vals[2*gj], vals[2*gj+1]);
                  end else begin : g_inner
                     assign node_next[gi][gj] = fp_add(node_reg[gi-1][2*gj], node_reg[gi-1][2*gj+1]);
                  end
               end else begin : g_idle
                  assign node_next[gi][gj] = FP_ZERO;
               end
            end
         end

         // Advance every tree level together; valid/last travel alongside the partial sums.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               valid_reg <= '0;
               last_reg  <= '0;
            end else if (en) begin
               node_reg     <= node_next;
               valid_reg[0] <= in_valid;
               last_reg[0]  <= in_last;
               for (int l = 1; l < LEVELS; l++) begin
                  valid_reg[l] <= valid_reg[l-1];
                  last_reg[l]  <= last_reg[l-1];
               end
            end
         end

         assign sum   = node_reg[LEVELS-1][0];
         assign valid = valid_reg[LEVELS-1];
         assign last  = last_reg[LEVELS-1];
      end
   endgenerate

endmodule

// File: rtl/dot_mac.sv
// Lane-parallel dot-product accumulator: input reg -> multipliers -> product reg -> adder tree -> accumulate/output.
module dot_mac
   import dot_mac_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CNT_W = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  ScalarVec_t       data   [LANES],
   input  ScalarVec_t       weight [LANES],
   output logic             out_valid,
   input  logic             out_ready,
   output `SINGLE           out_data,
   output logic [CNT_W-1:0] out_beats
);

   logic             stall;
   logic             adv;

   ScalarVec_t       data_reg   [LANES];
   ScalarVec_t       weight_reg [LANES];
   logic             in_valid_reg;
   logic             in_last_reg;

   logic [31:0]      prod_next [LANES];
   logic [31:0]      prod_reg  [LANES];
   logic             prod_valid_reg;
   logic             prod_last_reg;

   logic [31:0]      tree_sum;
   logic             tree_valid;
   logic             tree_last;

   logic [31:0]      acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [31:0]      beat_sum;
   logic [CNT_W-1:0] cnt_inc;

   logic             out_valid_reg;
   logic [31:0]      out_data_reg;
   logic [CNT_W-1:0] out_beats_reg;

   genvar gi;

   // A pending unaccepted result freezes the whole pipeline, so nothing is lost or duplicated.
   assign stall    = out_valid_reg && !out_ready;
   assign adv      = !stall;
   assign in_ready = !stall;

   // Capture the offered beat; in_ready equals adv, so any valid beat here is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_valid_reg <= 1'b0;
         in_last_reg  <= 1'b0;
      end else if (adv) begin
         in_valid_reg <= in_valid;
         in_last_reg  <= in_valid && in_last;
         data_reg     <= data;
         weight_reg   <= weight;
      end
   end

   // Per-lane products; a disabled lane on either side contributes +0.0.
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign prod_next[gi] = (data_reg[gi].valid && weight_reg[gi].valid)
                                ? fp_mul(data_reg[gi].value, weight_reg[gi].value)
                                : FP_ZERO;
      end
   endgenerate

   // Register the lane products ahead of the reduction tree.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prod_valid_reg <= 1'b0;
         prod_last_reg  <= 1'b0;
      end else if (adv) begin
         prod_reg       <= prod_next;
         prod_valid_reg <= in_valid_reg;
         prod_last_reg  <= in_last_reg;
      end
   end

   fp_add_tree #(
      .LANES (LANES)
   ) u_tree (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .in_valid (prod_valid_reg),
      .in_last  (prod_last_reg),
      .vals     (prod_reg),
      .sum      (tree_sum),
      .valid    (tree_valid),
      .last     (tree_last)
   );

   assign beat_sum = fp_add(acc_reg, tree_sum);
   assign cnt_inc  = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

   // Fold each beat into the running sum; a last beat publishes the total and restarts from +0.0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_reg       <= FP_ZERO;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= FP_ZERO;
         out_beats_reg <= '0;
      end else if (adv) begin
         out_valid_reg <= tree_valid && tree_last;
         if (tree_valid) begin
            if (tree_last) begin
               out_data_reg  <= beat_sum;
               out_beats_reg <= cnt_inc;
               acc_reg       <= FP_ZERO;
               cnt_reg       <= '0;
            end else begin
               acc_reg <= beat_sum;
               cnt_reg <= cnt_inc;
            end
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_beats = out_beats_reg;

endmodule
